// File: rtl/dmem_pkg.sv
// Shared widths and request types for the vector data-memory arbiter.
package dmem_pkg;
  localparam int unsigned DEF_DATA_SLOTS = 64;
  localparam int unsigned DEF_VECT_SIZE  = 8;
  localparam int unsigned DEF_ELEM_SIZE  = 8;
  localparam int unsigned DW             = DEF_ELEM_SIZE * DEF_VECT_SIZE;
  localparam int unsigned IDX_W          = $clog2(DEF_DATA_SLOTS);

  typedef logic [DW-1:0] vword_t;

  typedef struct packed {
    logic   we;
    vword_t addr;
    vword_t wdata;
  } dmem_req_t;
endpackage

// File: rtl/dmem_arbiter_rr.sv
// Round-robin arbiter: one-hot grant starting the search at rr_ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_c,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_c,
  output logic                       any_grant_c
);
  localparam int unsigned GIDX_W = $clog2(NUM_REQ);

  logic [GIDX_W-1:0] rr_ptr;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    any_grant_c = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_grant_c && req_c[GIDX_W'((32'(rr_ptr) + k) % NUM_REQ)]) begin
        any_grant_c = 1'b1;
        grant_idx_c = GIDX_W'((32'(rr_ptr) + k) % NUM_REQ);
        grant_c[GIDX_W'((32'(rr_ptr) + k) % NUM_REQ)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (any_grant_c) begin
      rr_ptr <= (grant_idx_c == GIDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + GIDX_W'(1);
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem sharing: round-robin grant, range check, registered response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_SLOTS = DEF_DATA_SLOTS,
  parameter int unsigned VECT_SIZE  = DEF_VECT_SIZE,
  parameter int unsigned ELEM_SIZE  = DEF_ELEM_SIZE,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0]                     req_we,
  input  logic [NUM_REQ*ELEM_SIZE*VECT_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*ELEM_SIZE*VECT_SIZE-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                     resp_valid,
  output logic [ELEM_SIZE*VECT_SIZE-1:0]         resp_rdata,
  output logic                                   resp_err,
  output logic                                   mem_we,
  output logic [ELEM_SIZE*VECT_SIZE-1:0]         mem_a,
  output logic [ELEM_SIZE*VECT_SIZE-1:0]         mem_wd,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0]         mem_rd
);
  localparam int unsigned DATA_W = ELEM_SIZE * VECT_SIZE;
  localparam int unsigned GIDX_W = $clog2(NUM_REQ);
  localparam logic [DATA_W-3:0] SLOT_LIMIT = (DATA_W-2)'(DATA_SLOTS);

  logic [NUM_REQ-1:0] grant_c;
  logic [GIDX_W-1:0]  grant_idx_c;
  logic               any_grant_c;
  logic               sel_we_c;
  logic [DATA_W-1:0]  sel_addr_c;
  logic [DATA_W-1:0]  sel_wdata_c;
  logic               err_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_c       (req_valid & {NUM_REQ{en}}),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .any_grant_c (any_grant_c)
  );

  // Winner's request fields; all zero when nobody is granted.
  always_comb begin
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (any_grant_c && (32'(grant_idx_c) == k)) begin
        sel_we_c    = req_we[k];
        sel_addr_c  = req_addr[k*DATA_W +: DATA_W];
        sel_wdata_c = req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Full word index is compared, so stray upper address bits also flag an error.
  assign err_c     = any_grant_c && (sel_addr_c[DATA_W-1:2] >= SLOT_LIMIT);
  assign req_ready = grant_c;
  assign mem_a     = sel_addr_c;
  assign mem_wd    = sel_wdata_c;
  assign mem_we    = sel_we_c & ~err_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= grant_c;
      resp_err   <= err_c;
      resp_rdata <= (any_grant_c && !sel_we_c && !err_c) ? mem_rd : '0;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter with a behavioural single-port dmem.
module tb_dmem_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned W  = 64;
  localparam logic [63:0] M0  = 64'h1111_0000_0000_0000;
  localparam logic [63:0] A5  = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] CD  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CF  = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] BAD = 64'hDEAD_BEEF_DEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n, en;
  logic [NR-1:0] req_valid, req_ready, req_we, resp_valid;
  logic [NR*W-1:0] req_addr, req_wdata;
  logic [W-1:0] resp_rdata, mem_a, mem_wd, mem_rd;
  logic resp_err, mem_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_SLOTS(64), .VECT_SIZE(8), .ELEM_SIZE(8), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // dmem: writes on the edge, reads combinationally.
  logic [63:0] mem [64];
  logic init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= M0 | 64'(i);
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end
  assign mem_rd = mem[mem_a[7:2]];

  typedef struct {
    logic        en;
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [63:0] a0, a1, d0, d1;
    logic [1:0]  ready;
    logic        mwe;
    logic [63:0] ma;
    logic [1:0]  rv;
    logic [63:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic e, logic [1:0] v, logic [1:0] w,
                              logic [63:0] a0, logic [63:0] a1,
                              logic [63:0] d0, logic [63:0] d1,
                              logic [1:0] rdy, logic mwe, logic [63:0] ma,
                              logic [1:0] rv, logic [63:0] rd, logic err);
    vec_t t;
    t.en = e; t.valid = v; t.we = w; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.ready = rdy; t.mwe = mwe; t.ma = ma; t.rv = rv; t.rd = rd; t.err = err;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [1:0] v, input logic [1:0] w,
                       input logic [63:0] a0, input logic [63:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1);
    en = e; req_valid = v; req_we = w;
    req_addr = {a1, a0}; req_wdata = {d1, d0};
  endtask

  initial begin
    rst_n = 1'b0; init_mem = 1'b1;
    drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);

    // Table: one vector per cycle, response checked after that cycle's edge.
    vecs.push_back(mk(1, 2'b11, 2'b00, 64'h0,   64'h8, 0,  0,   2'b01, 0, 64'h0,   2'b01, M0, 0));
    vecs.push_back(mk(1, 2'b01, 2'b01, 64'h10,  64'h0, A5, 0,   2'b01, 1, 64'h10,  2'b01, 0,  0));
    vecs.push_back(mk(1, 2'b01, 2'b00, 64'h10,  64'h0, 0,  0,   2'b01, 0, 64'h10,  2'b01, A5, 0));
    vecs.push_back(mk(1, 2'b10, 2'b00, 64'h0,   64'h8, 0,  0,   2'b10, 0, 64'h8,   2'b10, M0 | 64'd2, 0));
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        vecs.push_back(mk(1, 2'b11, 2'b00, 64'h0, 64'h4, 0, 0, 2'b01, 0, 64'h0, 2'b01, M0, 0));
      else
        vecs.push_back(mk(1, 2'b11, 2'b00, 64'h0, 64'h4, 0, 0, 2'b10, 0, 64'h4, 2'b10, M0 | 64'd1, 0));
    end
    vecs.push_back(mk(1, 2'b10, 2'b10, 64'h0,   64'h100, 0, BAD, 2'b10, 0, 64'h100,  2'b10, 0,  1));
    vecs.push_back(mk(1, 2'b10, 2'b00, 64'h0,   64'h0,   0, 0,   2'b10, 0, 64'h0,    2'b10, M0, 0));
    vecs.push_back(mk(1, 2'b01, 2'b00, 64'h1000, 64'h0,  0, 0,   2'b01, 0, 64'h1000, 2'b01, 0,  1));
    vecs.push_back(mk(1, 2'b01, 2'b01, 64'hFC,  64'h0,   CD, 0,  2'b01, 1, 64'hFC,   2'b01, 0,  0));
    vecs.push_back(mk(1, 2'b10, 2'b00, 64'h0,   64'hFC,  0, 0,   2'b10, 0, 64'hFC,   2'b10, CD, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 2'b11, 2'b11, 64'h0, 64'h4, BAD, BAD, 2'b00, 0, 64'h0, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b11, 2'b00, 64'h0,   64'h4,   0, 0,   2'b01, 0, 64'h0,    2'b01, M0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 2'b10, 2'b00, 64'h0, 64'h4, 0, 0, 2'b10, 0, 64'h4, 2'b10, M0 | 64'd1, 0));
    vecs.push_back(mk(1, 2'b00, 2'b00, 64'h0,   64'h0,   0, 0,   2'b00, 0, 64'h0,    2'b00, 0,  0));
    vecs.push_back(mk(1, 2'b01, 2'b01, 64'h14,  64'h0,   CF, 0,  2'b01, 1, 64'h14,   2'b01, 0,  0));
    vecs.push_back(mk(1, 2'b10, 2'b00, 64'h0,   64'h14,  0, 0,   2'b10, 0, 64'h14,   2'b10, CF, 0));

    // Reset state, including a request held valid across a reset edge.
    repeat (2) @(posedge clk);
    #1;
    chk("rst resp_valid", 64'(resp_valid), 64'h0);
    chk("rst resp_rdata", resp_rdata, 64'h0);
    chk("rst resp_err", 64'(resp_err), 64'h0);
    @(negedge clk);
    init_mem = 1'b0;
    drive(1'b1, 2'b01, 2'b00, 64'h8, 64'h0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst held req resp_valid", 64'(resp_valid), 64'h0);
    chk("rst held req resp_rdata", resp_rdata, 64'h0);
    @(negedge clk);
    drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      #1;
      chk($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vecs[i].ready));
      chk($sformatf("v%0d mem_we", i), 64'(mem_we), 64'(vecs[i].mwe));
      chk($sformatf("v%0d mem_a", i), mem_a, vecs[i].ma);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d resp_valid", i), 64'(resp_valid), 64'(vecs[i].rv));
      chk($sformatf("v%0d resp_rdata", i), resp_rdata, vecs[i].rd);
      chk($sformatf("v%0d resp_err", i), 64'(resp_err), 64'(vecs[i].err));
    end

    // Async reset right after a read response: response dropped, pointer cleared.
    @(negedge clk);
    drive(1'b1, 2'b01, 2'b00, 64'h8, 64'h0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre-rst resp_valid", 64'(resp_valid), 64'h1);
    chk("pre-rst resp_rdata", resp_rdata, M0 | 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst resp_valid", 64'(resp_valid), 64'h0);
    chk("async rst resp_rdata", resp_rdata, 64'h0);
    @(negedge clk);
    drive(1'b1, 2'b11, 2'b00, 64'h0, 64'h4, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("post-rst req_ready", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("post-rst resp_valid", 64'(resp_valid), 64'h1);
    chk("post-rst resp_rdata", resp_rdata, M0);
    @(negedge clk);
    drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
    @(posedge clk);
    #1;
    chk("idle resp_valid", 64'(resp_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
